// File: rtl/bp_me_pkg.sv
// Shared definitions for the IO load arbiter and its tag FIFO.
package bp_me_pkg;

  localparam int io_arb_max_src_gp = 4;

  typedef logic [1:0] io_arb_src_id_t;

  // Round-robin successor of a source id, wrapping at num_src.
  function automatic io_arb_src_id_t io_arb_next_src(io_arb_src_id_t s, int num_src);
    if (int'(s) + 1 >= num_src) return '0;
    else return io_arb_src_id_t'(int'(s) + 1);
  endfunction

endpackage

// File: rtl/bp_me_io_arb_tag_fifo.sv
// Tag FIFO: records which source owns each in-flight command, in issue order.
// Depth must be a power of two so the pointers wrap naturally.
module bp_me_io_arb_tag_fifo
  import bp_me_pkg::*;
#(
  parameter int depth_p = 8,
  localparam int ptr_w_lp = $clog2(depth_p),
  localparam int cnt_w_lp = $clog2(depth_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enq_v_i,
  input  io_arb_src_id_t      enq_data_i,
  input  logic                deq_v_i,
  output io_arb_src_id_t      deq_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [cnt_w_lp-1:0] count_o
);

  io_arb_src_id_t      mem_q [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_q;
  logic [ptr_w_lp-1:0] rd_ptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                enq;
  logic                deq;

  assign full_o     = (count_q == cnt_w_lp'(depth_p));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign deq_data_o = mem_q[rd_ptr_q];
  assign enq        = enq_v_i & ~full_o;
  assign deq        = deq_v_i & ~empty_o;

  // Storage, pointers and occupancy; simultaneous enq/deq leaves count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < depth_p; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= enq_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_io_load_arbiter.sv
// Merges N loader command streams onto one IO command channel with
// round-robin arbitration and a credit limit, and steers in-order responses
// back to the issuing loader via a tag FIFO.
// Optional feature macro: BP_IO_ARB_STATS_EN (per-source saturating issue counters).
module bp_me_io_load_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_src_p         = 2,
  parameter int max_outstanding_p = 8,
  parameter int io_msg_w_p        = 64,
  localparam int cnt_w_lp         = $clog2(max_outstanding_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [num_src_p*io_msg_w_p-1:0] src_cmd_i,
  input  logic [num_src_p-1:0]            src_cmd_v_i,
  output logic [num_src_p-1:0]            src_cmd_yumi_o,
  output logic [io_msg_w_p-1:0]           src_resp_o,
  output logic [num_src_p-1:0]            src_resp_v_o,
  input  logic [num_src_p-1:0]            src_resp_ready_i,
  output logic [io_msg_w_p-1:0]           io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,
  input  logic [io_msg_w_p-1:0]           io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic [cnt_w_lp-1:0]             outstanding_o,
  output logic                            error_o,
  output logic [num_src_p*32-1:0]         issue_cnt_o
);

  io_arb_src_id_t rr_ptr_q;
  io_arb_src_id_t grant;
  io_arb_src_id_t owner;
  logic           fifo_full;
  logic           fifo_empty;
  logic           issue;
  logic           resp_v;
  logic           owner_ready;
  logic           error_q;

  // Round-robin pick: first valid source at or after the pointer.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < num_src_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (!found && src_cmd_v_i[idx]) begin
        grant = io_arb_src_id_t'(idx);
        found = 1'b1;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign io_cmd_v_o = reset_n_i & (|src_cmd_v_i) & ~fifo_full;
  assign issue      = io_cmd_v_o & io_cmd_ready_i;
  assign io_cmd_o   = reset_n_i ? src_cmd_i[int'(grant)*io_msg_w_p +: io_msg_w_p] : '0;
  assign resp_v     = reset_n_i & io_resp_v_i & ~fifo_empty;
  assign src_resp_o = reset_n_i ? io_resp_i : '0;

  // One-hot steering of yumi/resp-valid and selection of the owner's ready.
  always_comb begin
    src_cmd_yumi_o = '0;
    src_resp_v_o   = '0;
    owner_ready    = 1'b0;
    for (int s = 0; s < num_src_p; s++) begin
      src_cmd_yumi_o[s] = issue && (grant == io_arb_src_id_t'(s));
      src_resp_v_o[s]   = resp_v && (owner == io_arb_src_id_t'(s));
      if (owner == io_arb_src_id_t'(s)) owner_ready = src_resp_ready_i[s];
    end
  end

  assign io_resp_yumi_o = resp_v & owner_ready;
  assign error_o        = error_q;

  bp_me_io_arb_tag_fifo #(
    .depth_p(max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_v_i   (issue),
    .enq_data_i(grant),
    .deq_v_i   (io_resp_yumi_o),
    .deq_data_o(owner),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

  // Pointer moves past the granted source only when a command issues.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rr_ptr_q <= '0;
    else if (issue) rr_ptr_q <= io_arb_next_src(grant, num_src_p);
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else if (io_resp_v_i && fifo_empty) error_q <= 1'b1;
  end

`ifdef BP_IO_ARB_STATS_EN
  for (genvar s = 0; s < num_src_p; s++) begin : g_stats
    logic [31:0] cnt_q;
    // Saturating per-source issue counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else if (src_cmd_yumi_o[s] && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
    end
    assign issue_cnt_o[s*32 +: 32] = cnt_q;
  end
`else
  assign issue_cnt_o = '0;
`endif

endmodule
